ahb_sram_wide: RTL and testbench
================================

# ahb_sram_wide

AHB-Lite SRAM slave, parametrised successor of the single-width zero-wait SRAM slave. Supports a 32- or 64-bit data bus, configurable depth, byte/halfword/word/doubleword writes via byte lanes, and a programmable number of read wait states. Read-after-write hazards are handled by data forwarding. The block sits behind the AHB decoder/mux as a leaf slave, with a behavioural memory array inside.

## Interface
- mem_dw, 32, data width in bits; 32 or 64 only.
- mem_depth, 1024, number of mem_dw-wide words.
- mem_abit, 10, word-address bits; equals log2(mem_depth).
- rd_ws, 1, read wait states inserted per read data phase; 0..3.
- lane_bit, derived, log2(mem_dw/8): 2 for 32-bit, 3 for 64-bit.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  mem_abit+lane_bit  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  0 = byte, 1 = half, 2 = word, 3 = dword.
- hburst  in  3  accepted; ignored (the master supplies every beat address).
- hprot  in  4  accepted; ignored.
- hwrite  in  1  1 = write.
- hwdata  in  mem_dw  write data, valid in the data phase.
- hready  in  1  bus-wide ready.
- hreadyout  out  1  slave ready.
- hrdata  out  mem_dw  read data.
- hresp  out  2  0 = OKAY, 1 = ERROR.

## Operation
- Transfer accepted: `hsel & hready & htrans[1]`. IDLE, BUSY, and unselected cycles get a zero-wait OKAY and cause no array access.
- On acceptance, the block registers these address-phase values: word address, byte-lane mask, hwrite, hsize.
- Byte-lane mask: `(2^(2^hsize)-1) << haddr[lane_bit-1:0]`, truncated to mem_dw/8 bits.
- FSM states: IDLE, WR, RD_WAIT, RD_DATA, ERR1, ERR2.
  - IDLE → WR on an accepted write.
  - IDLE → RD_WAIT on an accepted read when rd_ws > 0.
  - IDLE → RD_DATA on an accepted read when rd_ws = 0.
  - WR and RD_DATA complete in one cycle. They return to IDLE, or go straight to the next state if a new transfer is accepted in the same cycle (pipelined back-to-back).
  - RD_WAIT counts down a 2-bit counter loaded with rd_ws-1, then moves to RD_DATA.
- Write: the enabled byte lanes of hwdata are written at the clock edge that ends WR.
- Read: the array is read from the registered word address. hrdata is held stable while hreadyout = 1 in RD_DATA.
- Forwarding: a read whose address phase coincides with a WR data phase to the same word gets the merged bytes from that write. There is no stale data.
- Reset (any time, including mid-burst): FSM → IDLE, counter → 0, hreadyout = 1, hresp = 0, hrdata = 0. Array contents are not reset. A write in flight is dropped.

## Timing
- Write: zero wait states. Address phase at cycle N, data phase N+1 with hreadyout = 1; the array is updated at the end of N+1.
- Read: address phase at N. hreadyout is low for cycles N+1 .. N+rd_ws. Data is valid with hreadyout = 1 at N+1+rd_ws.
- New address phases are sampled only while hready = 1. During wait states the master holds the address, and the slave does not re-sample it.
- Back-to-back writes: one beat per cycle.
- Back-to-back reads: one beat per (1+rd_ws) cycles.

## Configuration
- AHB_SRAM_ERR_EN defined: an accepted transfer is answered with the standard two-cycle ERROR and has no array effect if it is either:
  - unaligned (`haddr mod 2^hsize ≠ 0`), or
  - oversized (`8·2^hsize > mem_dw`).
  - The ERROR sequence is ERR1 (hreadyout = 0, hresp = 1) then ERR2 (hreadyout = 1, hresp = 1), then IDLE.
  - A transfer accepted during ERR2 is processed normally.
- AHB_SRAM_ERR_EN undefined:
  - hresp is tied to 0 and the ERR states are absent.
  - Unaligned addresses are force-aligned: the low hsize bits are cleared.
  - Oversized hsize is treated as full width.

## Test plan
- After reset: hreadyout = 1, hresp = 0, hrdata = 0. With mem_dw = 32, write 0xDEADBEEF to 0x10, then read 0x10 (rd_ws = 1) → one low hreadyout cycle, then hrdata = 0xDEADBEEF.
- Byte write 0xAA at 0x13, then word read 0x10 → 0xAAADBEEF. Halfword write 0x1234 at 0x10 → 0xAAAD1234.
- Write 0x5555AAAA to 0x20 immediately followed by a read of 0x20 (pipelined) → 0x5555AAAA via forwarding. Four-beat SEQ write burst 0x40..0x4C followed by a read burst returns identical data.
- mem_dw = 64, rd_ws = 0: dword write 0x0123456789ABCDEF at 0x8, read back → the same value with zero wait states on every beat.
- With AHB_SRAM_ERR_EN: word write at 0x12 → ERR1/ERR2 (hresp = 1, hreadyout 0 then 1); a later read of 0x10 shows unchanged data. Without the macro: the same write lands at 0x10.
- Assert rstn mid read wait state → hreadyout = 1 and hrdata = 0 immediately. After release, earlier written data still reads back.

Source files
------------

// File: rtl/ahb_sram_wide.sv
// AHB-Lite SRAM leaf slave: 32/64-bit data, byte-lane writes, rd_ws read wait states, forwarded RAW.
// Optional feature macro AHB_SRAM_ERR_EN: ERROR response for unaligned or oversized transfers.
module ahb_sram_wide #(
   parameter int mem_dw    = 32,
   parameter int mem_depth = 1024,
   parameter int mem_abit  = 10,
   parameter int rd_ws     = 1,
   localparam int lane_bit = (mem_dw == 64) ? 3 : 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         hsel,
   input  logic [mem_abit+lane_bit-1:0] haddr,
   input  logic [1:0]                   htrans,
   input  logic [2:0]                   hsize,
   input  logic [2:0]                   hburst,
   input  logic [3:0]                   hprot,
   input  logic                         hwrite,
   input  logic [mem_dw-1:0]            hwdata,
   input  logic                         hready,
   output logic                         hreadyout,
   output logic [mem_dw-1:0]            hrdata,
   output logic [1:0]                   hresp
);

   localparam int         nb      = mem_dw / 8;
   localparam bit         has_ws  = (rd_ws > 0);
   localparam logic [1:0] ws_load = has_ws ? 2'(rd_ws - 1) : 2'd0;

`ifdef AHB_SRAM_ERR_EN
   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_WAIT, S_RD_DATA, S_ERR1, S_ERR2
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_WR, S_RD_WAIT, S_RD_DATA
   } state_e;
`endif

   state_e              state_q, state_d, accept_state;
   logic [1:0]          cnt_q, cnt_d;
   logic [mem_abit-1:0] addr_q, addr_d;
   logic [nb-1:0]       mask_q, mask_d;
   logic [mem_dw-1:0]   rdata_q, rdata_d;

   logic [mem_dw-1:0]   mem [mem_depth];

   logic                take;
   logic [mem_abit-1:0] word_addr;
   logic [2:0]          eff_size;
   logic [lane_bit-1:0] align;
   logic [lane_bit-1:0] base;
   int                  span;
   logic [nb-1:0]       lane_mask;
   logic [mem_abit-1:0] rd_addr;
   logic [mem_dw-1:0]   rd_word;
   logic [mem_dw-1:0]   fwd_word;
   logic                unused_ok;

   // hwrite and hsize are fully captured by the next state and the lane mask.
   assign unused_ok = &{1'b0, hburst, hprot, htrans[0]};

   // A new address phase is only sampled in states that drive hreadyout high.
   assign take      = hsel & hready & htrans[1] & hreadyout;
   assign word_addr = haddr[mem_abit+lane_bit-1:lane_bit];

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      eff_size = (hsize > 3'(lane_bit)) ? 3'(lane_bit) : hsize;
      for (int b = 0; b < lane_bit; b++) align[b] = (b < int'(hsize));
      base = haddr[lane_bit-1:0] & ~align;
      span = 1 << eff_size;
      for (int b = 0; b < nb; b++) begin
         lane_mask[b] = (b >= int'(base)) && (b < int'(base) + span);
      end
   end

`ifdef AHB_SRAM_ERR_EN
   logic bad_xfer;
   assign bad_xfer = (hsize > 3'(lane_bit)) || (|(haddr[lane_bit-1:0] & align));
`endif

   always_comb begin
      accept_state = S_IDLE;
      if (take) begin
         if (hwrite)      accept_state = S_WR;
         else if (has_ws) accept_state = S_RD_WAIT;
         else             accept_state = S_RD_DATA;
`ifdef AHB_SRAM_ERR_EN
         if (bad_xfer) accept_state = S_ERR1;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE, S_WR, S_RD_DATA: state_d = accept_state;
         S_RD_WAIT: begin
            if (cnt_q == 2'd0) state_d = S_RD_DATA;
            else               cnt_d   = cnt_q - 2'd1;
         end
`ifdef AHB_SRAM_ERR_EN
         S_ERR1: state_d = S_ERR2;
         S_ERR2: state_d = accept_state;
`endif
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         addr_d = word_addr;
         mask_d = lane_mask;
         cnt_d  = ws_load;
      end
   end

   // Zero-wait reads fetch at the address-phase edge, the same edge that commits
   // a pending write, so the write's enabled lanes are merged over the array word.
   always_comb begin
      rd_addr = (state_q == S_RD_WAIT) ? addr_q : word_addr;
      rd_word = mem[rd_addr];
      for (int b = 0; b < nb; b++) begin
         fwd_word[b*8 +: 8] = (state_q == S_WR && rd_addr == addr_q && mask_q[b])
                              ? hwdata[b*8 +: 8] : rd_word[b*8 +: 8];
      end
      rdata_d = (state_d == S_RD_DATA) ? fwd_word : rdata_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         addr_q  <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
      end
   end

   // NOTE: the array has no reset; contents survive rstn and only state is cleared.
   always_ff @(posedge clk) begin
      if (state_q == S_WR) begin
         for (int b = 0; b < nb; b++) begin
            if (mask_q[b]) mem[addr_q][b*8 +: 8] <= hwdata[b*8 +: 8];
         end
      end
   end

   assign hrdata = rdata_q;

`ifdef AHB_SRAM_ERR_EN
   assign hreadyout = !(state_q == S_RD_WAIT || state_q == S_ERR1);
   assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
`else
   assign hreadyout = (state_q != S_RD_WAIT);
   assign hresp     = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_sram_wide.sv
// Scoreboard bench for ahb_sram_wide: a 32-bit/rd_ws=1 instance and a 64-bit/rd_ws=0 instance.
module tb_ahb_sram_wide;

   typedef struct {
      string       name;
      bit          rd;
      logic [63:0] data;
      logic [1:0]  resp;
      int          ws;
   } exp_t;

   localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn_a   [2];
   logic        hsel_a   [2];
   logic [12:0] haddr_a  [2];
   logic [1:0]  htrans_a [2];
   logic [2:0]  hsize_a  [2];
   logic        hwrite_a [2];
   logic [63:0] hwdata_a [2];
   logic [63:0] wpend    [2];

   logic [31:0] rd32;
   logic [63:0] rd64;
   logic        ro32, ro64;
   logic [1:0]  rs32, rs64;

   wire  [63:0] hrdata_a [2];
   wire         hready_a [2];
   wire  [1:0]  hresp_a  [2];
   assign hrdata_a[0] = {32'h0, rd32};
   assign hrdata_a[1] = rd64;
   assign hready_a[0] = ro32;
   assign hready_a[1] = ro64;
   assign hresp_a[0]  = rs32;
   assign hresp_a[1]  = rs64;

   ahb_sram_wide #(.mem_dw(32), .mem_depth(1024), .mem_abit(10), .rd_ws(1)) u_sram32 (
      .clk(clk), .rstn(rstn_a[0]), .hsel(hsel_a[0]), .haddr(haddr_a[0][11:0]),
      .htrans(htrans_a[0]), .hsize(hsize_a[0]), .hburst(3'd0), .hprot(4'd3),
      .hwrite(hwrite_a[0]), .hwdata(hwdata_a[0][31:0]), .hready(ro32),
      .hreadyout(ro32), .hrdata(rd32), .hresp(rs32)
   );

   ahb_sram_wide #(.mem_dw(64), .mem_depth(1024), .mem_abit(10), .rd_ws(0)) u_sram64 (
      .clk(clk), .rstn(rstn_a[1]), .hsel(hsel_a[1]), .haddr(haddr_a[1]),
      .htrans(htrans_a[1]), .hsize(hsize_a[1]), .hburst(3'd0), .hprot(4'd3),
      .hwrite(hwrite_a[1]), .hwdata(hwdata_a[1]), .hready(ro64),
      .hreadyout(ro64), .hrdata(rd64), .hresp(rs64)
   );

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s", name);
   endtask

   function automatic exp_t mk(input string name, input bit rd, input logic [63:0] data,
                               input logic [1:0] resp, input int ws);
      exp_t e;
      e.name = name; e.rd = rd; e.data = data; e.resp = resp; e.ws = ws;
      return e;
   endfunction

   task automatic sb_push(input int p, input exp_t e);
      if (p == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   function automatic bit sb_pop(input int p, output exp_t e);
      e = mk("none", 1'b0, 64'h0, 2'd0, 0);
      if (p == 0) begin
         if (sb0.size() == 0) return 1'b0;
         e = sb0.pop_front();
      end else begin
         if (sb1.size() == 0) return 1'b0;
         e = sb1.pop_front();
      end
      return 1'b1;
   endfunction

   // Monitor: tracks each accepted address phase through its data phase.
   for (genvar p = 0; p < 2; p++) begin : g_mon
      bit act = 1'b0;
      int ws  = 0;
      always @(negedge clk) begin
         exp_t e;
         if (!rstn_a[p]) begin
            act = 1'b0;
         end else begin
            if (act && hready_a[p]) begin
               act = 1'b0;
               if (!sb_pop(p, e)) fail_now($sformatf("p%0d unexpected completion", p));
               else begin
                  check($sformatf("p%0d %s waits", p, e.name), 64'(ws), 64'(e.ws));
                  check($sformatf("p%0d %s hresp", p, e.name), 64'(hresp_a[p]), 64'(e.resp));
                  if (e.rd) check($sformatf("p%0d %s hrdata", p, e.name), hrdata_a[p], e.data);
               end
            end else if (act) begin
               ws++;
            end
            if (hsel_a[p] && hready_a[p] && htrans_a[p][1]) begin
               act = 1'b1;
               ws  = 0;
            end
         end
      end
   end

   task automatic wait_ready(input int p);
      int g = 0;
      @(negedge clk);
      while (!hready_a[p] && g < 64) begin
         @(negedge clk);
         g++;
      end
      if (!hready_a[p]) fail_now($sformatf("p%0d hreadyout timeout", p));
   endtask

   task automatic xfer(input int p, input logic [12:0] a, input bit w, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [63:0] wd, input exp_t e);
      hsel_a[p]   = 1'b1;
      haddr_a[p]  = a;
      hwrite_a[p] = w;
      hsize_a[p]  = sz;
      htrans_a[p] = tr;
      hwdata_a[p] = wpend[p];
      wait_ready(p);
      @(posedge clk);
      #1;
      wpend[p] = wd;
      sb_push(p, e);
   endtask

   task automatic wr(input int p, input logic [12:0] a, input logic [2:0] sz,
                     input logic [63:0] wd, input logic [1:0] tr = T_NSEQ);
      xfer(p, a, 1'b1, sz, tr, wd, mk($sformatf("wr@%0h", a), 1'b0, 64'h0, 2'd0, 0));
   endtask

   task automatic wr_err(input int p, input logic [12:0] a, input logic [2:0] sz,
                         input logic [63:0] wd);
      xfer(p, a, 1'b1, sz, T_NSEQ, wd, mk($sformatf("errwr@%0h", a), 1'b0, 64'h0, 2'd1, 1));
   endtask

   task automatic rd(input int p, input logic [12:0] a, input logic [2:0] sz,
                     input logic [63:0] exp, input logic [1:0] tr = T_NSEQ);
      xfer(p, a, 1'b0, sz, tr, 64'h0, mk($sformatf("rd@%0h", a), 1'b1, exp, 2'd0, (p == 0) ? 1 : 0));
   endtask

   task automatic idle(input int p);
      hsel_a[p]   = 1'b0;
      htrans_a[p] = T_IDLE;
      hwdata_a[p] = wpend[p];
      wait_ready(p);
      @(posedge clk);
      #1;
      wpend[p] = 64'h0;
   endtask

   logic [31:0] burst [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

   initial begin
      for (int p = 0; p < 2; p++) begin
         rstn_a[p] = 1'b0; hsel_a[p] = 1'b0; haddr_a[p] = '0; htrans_a[p] = T_IDLE;
         hsize_a[p] = 3'd0; hwrite_a[p] = 1'b0; hwdata_a[p] = '0; wpend[p] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("p0 reset hreadyout", 64'(hready_a[0]), 64'd1);
      check("p0 reset hresp", 64'(hresp_a[0]), 64'd0);
      check("p0 reset hrdata", hrdata_a[0], 64'h0);
      check("p1 reset hrdata", hrdata_a[1], 64'h0);
      rstn_a[0] = 1'b1;
      rstn_a[1] = 1'b1;
      @(posedge clk);
      #1;

      // 32-bit, one read wait state
      wr(0, 13'h10, 3'd2, 64'hDEADBEEF);
      rd(0, 13'h10, 3'd2, 64'hDEADBEEF);
      idle(0);
      wr(0, 13'h13, 3'd0, 64'hAA00_0000);
      rd(0, 13'h10, 3'd2, 64'hAAADBEEF);
      wr(0, 13'h10, 3'd1, 64'h0000_1234);
      rd(0, 13'h10, 3'd2, 64'hAAAD1234);
      idle(0);
      wr(0, 13'h20, 3'd2, 64'h5555AAAA);
      rd(0, 13'h20, 3'd2, 64'h5555AAAA);
      idle(0);
      for (int i = 0; i < 4; i++) wr(0, 13'(32'h40 + 4 * i), 3'd2, 64'(burst[i]), (i == 0) ? T_NSEQ : T_SEQ);
      for (int i = 0; i < 4; i++) rd(0, 13'(32'h40 + 4 * i), 3'd2, 64'(burst[i]), (i == 0) ? T_NSEQ : T_SEQ);
      idle(0);
      wr(0, 13'h30, 3'd2, 64'h600DF00D);
`ifdef AHB_SRAM_ERR_EN
      wr_err(0, 13'h12, 3'd2, 64'hCAFEF00D);
      rd(0, 13'h10, 3'd2, 64'hAAAD1234);
      wr_err(0, 13'h30, 3'd3, 64'h0BADC0DE);
      rd(0, 13'h30, 3'd2, 64'h600DF00D);
`else
      wr(0, 13'h12, 3'd2, 64'hCAFEF00D);
      rd(0, 13'h10, 3'd2, 64'hCAFEF00D);
      wr(0, 13'h30, 3'd3, 64'h0BADC0DE);
      rd(0, 13'h30, 3'd2, 64'h0BADC0DE);
`endif
      idle(0);

      // reset in the middle of a read wait state
      hsel_a[0] = 1'b1; haddr_a[0] = 13'h20; hwrite_a[0] = 1'b0; hsize_a[0] = 3'd2;
      htrans_a[0] = T_NSEQ; hwdata_a[0] = wpend[0];
      wait_ready(0);
      @(posedge clk);
      #1;
      hsel_a[0] = 1'b0;
      htrans_a[0] = T_IDLE;
      check("p0 wait state before reset", 64'(hready_a[0]), 64'd0);
      rstn_a[0] = 1'b0;
      #1;
      check("p0 mid-read reset hreadyout", 64'(hready_a[0]), 64'd1);
      check("p0 mid-read reset hrdata", hrdata_a[0], 64'h0);
      check("p0 mid-read reset hresp", 64'(hresp_a[0]), 64'd0);
      @(posedge clk);
      #1;
      rstn_a[0] = 1'b1;
      wpend[0] = 64'h0;
      rd(0, 13'h20, 3'd2, 64'h5555AAAA);
      rd(0, 13'h44, 3'd2, 64'(burst[1]));
      idle(0);

      // 64-bit, zero read wait states, forwarding on every pipelined read
      wr(1, 13'h08, 3'd3, 64'h0123456789ABCDEF);
      rd(1, 13'h08, 3'd3, 64'h0123456789ABCDEF);
      wr(1, 13'h10, 3'd3, 64'h1122334455667788);
      rd(1, 13'h10, 3'd3, 64'h1122334455667788);
      wr(1, 13'h0C, 3'd2, 64'hFEEDFACE_0000_0000);
      rd(1, 13'h08, 3'd3, 64'hFEEDFACE89ABCDEF);
      rd(1, 13'h10, 3'd3, 64'h1122334455667788);
      rd(1, 13'h0C, 3'd2, 64'hFEEDFACE89ABCDEF);
      idle(1);

      repeat (3) @(posedge clk);
      #1;
      check("p0 scoreboard drained", 64'(sb0.size()), 64'd0);
      check("p1 scoreboard drained", 64'(sb1.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
